// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the four pipeline stage registers and the PC.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int WAIT_CNT_WIDTH = 8,
  parameter int MEM_TIMEOUT    = 200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rt_addr,
  input  logic                      dec_rs_used,
  input  logic                      dec_rt_used,
  input  logic                      exec_mem_enable,
  input  logic                      exec_mem_rw,
  input  logic                      exec_wb_reg,
  input  logic [REG_ADDR_WIDTH-1:0] exec_write_addr,
  input  logic                      exec_branch_taken,
  input  logic                      free_list_empty,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  output logic                      pc_stall,
  output logic                      pc_redirect,
  output logic                      stall_f2d,
  output logic                      flush_f2d,
  output logic                      stall_d2e,
  output logic                      flush_d2e,
  output logic                      stall_e2m,
  output logic                      flush_e2m,
  output logic                      stall_m2w,
  output logic                      flush_m2w,
  output logic                      mem_timeout,
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_flush_count
);

  typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_REDIRECT} state_t;

  localparam logic [WAIT_CNT_WIDTH-1:0] TIMEOUT_CNT = WAIT_CNT_WIDTH'(MEM_TIMEOUT);

  state_t                    state_reg, state_next;
  logic                      redirect_pending_reg, redirect_pending_next;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_reg, wait_cnt_next;
  logic                      mem_timeout_reg;

  logic mem_wait, rs_match, rt_match, load_use, squash_f2d;

  assign mem_wait = mem_req && !mem_ready;
  assign rs_match = dec_rs_used && (dec_rs_addr == exec_write_addr);
  assign rt_match = dec_rt_used && (dec_rt_addr == exec_write_addr);
  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = exec_mem_enable && !exec_mem_rw && exec_wb_reg &&
                    (exec_write_addr != '0) && (rs_match || rt_match);

  always_comb begin
    pc_stall              = 1'b0;
    pc_redirect           = 1'b0;
    stall_f2d             = 1'b0;
    flush_f2d             = 1'b0;
    stall_d2e             = 1'b0;
    flush_d2e             = 1'b0;
    stall_e2m             = 1'b0;
    flush_e2m             = 1'b0;
    stall_m2w             = 1'b0;
    flush_m2w             = 1'b0;
    squash_f2d            = 1'b0;
    state_next            = state_reg;
    redirect_pending_next = redirect_pending_reg;
    wait_cnt_next         = '0;

    if (rst) begin
      flush_f2d = 1'b1;
      flush_d2e = 1'b1;
      flush_e2m = 1'b1;
      flush_m2w = 1'b1;
    end else if (mem_wait) begin
      // Branch in execute is held, not acted on, until memory completes
      pc_stall   = 1'b1;
      stall_f2d  = 1'b1;
      stall_d2e  = 1'b1;
      stall_e2m  = 1'b1;
      flush_m2w  = 1'b1;
      state_next = ST_MEM_WAIT;
      if (state_reg == ST_REDIRECT) redirect_pending_next = 1'b1;
      wait_cnt_next = (wait_cnt_reg == '1) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
    end else begin
      // Squash the wrong-path fetch left over from a redirect
      squash_f2d = (state_reg == ST_REDIRECT) ||
                   ((state_reg == ST_MEM_WAIT) && redirect_pending_reg);
      flush_f2d             = squash_f2d;
      redirect_pending_next = 1'b0;
      state_next            = ST_RUN;
      if (exec_branch_taken) begin
        pc_redirect = 1'b1;
        flush_f2d   = 1'b1;
        flush_d2e   = 1'b1;
        state_next  = ST_REDIRECT;
      end else if (load_use || free_list_empty) begin
        pc_stall  = 1'b1;
        stall_f2d = !squash_f2d;
        flush_d2e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg            <= ST_RUN;
      redirect_pending_reg <= 1'b0;
      wait_cnt_reg         <= '0;
      mem_timeout_reg      <= 1'b0;
    end else begin
      state_reg            <= state_next;
      redirect_pending_reg <= redirect_pending_next;
      wait_cnt_reg         <= wait_cnt_next;
      if (mem_wait && (wait_cnt_next == TIMEOUT_CNT)) mem_timeout_reg <= 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_reg, perf_flush_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_reg <= '0;
      perf_flush_reg <= '0;
    end else begin
      if (pc_stall && (perf_stall_reg != '1))    perf_stall_reg <= perf_stall_reg + 1'b1;
      if (pc_redirect && (perf_flush_reg != '1)) perf_flush_reg <= perf_flush_reg + 1'b1;
    end
  end

  assign perf_stall_cycles = perf_stall_reg;
  assign perf_flush_count  = perf_flush_reg;
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int AW         = 5;
  localparam int TB_TIMEOUT = 4;

  // Expected-vector bit order: ps pr sf ff sd fd se fe sm fm
  localparam logic [9:0] V_IDLE   = 10'b0000000000;
  localparam logic [9:0] V_RESET  = 10'b0001010101;
  localparam logic [9:0] V_HAZ    = 10'b1010010000;
  localparam logic [9:0] V_HAZ_SQ = 10'b1001010000;
  localparam logic [9:0] V_BRANCH = 10'b0101010000;
  localparam logic [9:0] V_SQUASH = 10'b0001000000;
  localparam logic [9:0] V_MWAIT  = 10'b1010101001;

  typedef struct packed {
    logic          r;
    logic          br;
    logic          ld;
    logic [AW-1:0] wa;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          fle;
    logic          mq;
    logic          mr;
    logic [9:0]    want;
  } step_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] dec_rs_addr, dec_rt_addr, exec_write_addr;
  logic          dec_rs_used, dec_rt_used, exec_mem_enable, exec_mem_rw, exec_wb_reg;
  logic          exec_branch_taken, free_list_empty, mem_req, mem_ready;
  logic          pc_stall, pc_redirect, stall_f2d, flush_f2d, stall_d2e, flush_d2e;
  logic          stall_e2m, flush_e2m, stall_m2w, flush_m2w, mem_timeout;
  logic [31:0]   perf_stall_cycles, perf_flush_count;

  pipeline_hazard_ctrl #(
    .REG_ADDR_WIDTH(AW),
    .WAIT_CNT_WIDTH(8),
    .MEM_TIMEOUT   (TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .dec_rs_addr(dec_rs_addr), .dec_rt_addr(dec_rt_addr),
    .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used),
    .exec_mem_enable(exec_mem_enable), .exec_mem_rw(exec_mem_rw),
    .exec_wb_reg(exec_wb_reg), .exec_write_addr(exec_write_addr),
    .exec_branch_taken(exec_branch_taken), .free_list_empty(free_list_empty),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .pc_redirect(pc_redirect),
    .stall_f2d(stall_f2d), .flush_f2d(flush_f2d),
    .stall_d2e(stall_d2e), .flush_d2e(flush_d2e),
    .stall_e2m(stall_e2m), .flush_e2m(flush_e2m),
    .stall_m2w(stall_m2w), .flush_m2w(flush_m2w),
    .mem_timeout(mem_timeout),
    .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state: what happened in earlier cycles, in spec terms
  bit m_after_branch;   // previous cycle acted on a taken branch (REDIRECT cycle now)
  bit m_pending;        // a memory wait interrupted the REDIRECT cycle
  bit m_in_wait;        // previous cycle was a memory wait
  int m_wait_cycles;    // consecutive wait cycles so far
  bit m_timeout;
  int m_stalls;
  int m_flushes;

  function automatic logic [9:0] obs();
    return {pc_stall, pc_redirect, stall_f2d, flush_f2d, stall_d2e, flush_d2e,
            stall_e2m, flush_e2m, stall_m2w, flush_m2w};
  endfunction

  function automatic logic [9:0] model_exp();
    logic [9:0] e;
    bit hit, squash;
    e = '0;
    hit = exec_mem_enable && !exec_mem_rw && exec_wb_reg && exec_write_addr != 0 &&
          ((dec_rs_used && dec_rs_addr == exec_write_addr) ||
           (dec_rt_used && dec_rt_addr == exec_write_addr));
    if (rst) begin
      e = V_RESET;
    end else if (mem_req && !mem_ready) begin
      e = V_MWAIT;
    end else begin
      squash = m_after_branch || (m_in_wait && m_pending);
      if (squash) e = V_SQUASH;
      if (exec_branch_taken) e = V_BRANCH;
      else if (hit || free_list_empty) e = squash ? V_HAZ_SQ : V_HAZ;
    end
    return e;
  endfunction

  function automatic logic [31:0] exp_stalls();
`ifdef HAZARD_PERF_CNT_EN
    return 32'(m_stalls);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_flushes();
`ifdef HAZARD_PERF_CNT_EN
    return 32'(m_flushes);
`else
    return 32'd0;
`endif
  endfunction

  // Advance one clock and update the model with the inputs that were applied
  task automatic tick();
    logic [9:0] e;
    e = model_exp();
    @(posedge clk);
    if (rst) begin
      m_after_branch = 0; m_pending = 0; m_in_wait = 0;
      m_wait_cycles = 0; m_timeout = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (e[9]) m_stalls++;
      if (e[8]) m_flushes++;
      if (mem_req && !mem_ready) begin
        if (m_after_branch) m_pending = 1;
        m_in_wait = 1;
        m_wait_cycles++;
        if (m_wait_cycles == TB_TIMEOUT) m_timeout = 1;
        m_after_branch = 0;
      end else begin
        m_after_branch = exec_branch_taken;
        m_in_wait = 0; m_pending = 0; m_wait_cycles = 0;
      end
    end
    #1;
  endtask

  task automatic apply(input step_t s);
    rst               = s.r;
    exec_branch_taken = s.br;
    exec_mem_enable   = s.ld;
    exec_mem_rw       = 1'b0;
    exec_wb_reg       = s.ld;
    exec_write_addr   = s.wa;
    dec_rs_addr       = s.rs;
    dec_rt_addr       = s.rt;
    dec_rs_used       = 1'b1;
    dec_rt_used       = 1'b1;
    free_list_empty   = s.fle;
    mem_req           = s.mq;
    mem_ready         = s.mr;
  endtask

  task automatic test_reset();
    apply('{r:1, br:1, ld:1, wa:5'd3, rs:5'd3, rt:5'd3, fle:1, mq:1, mr:0, want:V_RESET});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== V_RESET) begin
        bad++; $display("FAIL reset_outputs[%0d] got=%b want=%b", i, obs(), V_RESET);
      end
      if (i == 1) begin
        total++;
        if (mem_timeout !== 1'b0 || perf_stall_cycles !== 32'd0 || perf_flush_count !== 32'd0) begin
          bad++; $display("FAIL reset_state timeout=%b stalls=%0d flushes=%0d want 0/0/0",
                          mem_timeout, perf_stall_cycles, perf_flush_count);
        end
      end
      tick();
    end
    apply('{r:0, br:0, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:0, mr:0, want:V_IDLE});
    @(negedge clk);
    total++;
    if (obs() !== V_IDLE) begin
      bad++; $display("FAIL reset_release got=%b want=%b", obs(), V_IDLE);
    end
    tick();
  endtask

  task automatic test_load_use();
    step_t s [6];
    s = '{'{r:0, br:0, ld:1, wa:5'd5, rs:5'd31, rt:5'd5,  fle:0, mq:0, mr:0, want:V_HAZ},
          '{r:0, br:0, ld:0, wa:5'd5, rs:5'd31, rt:5'd5,  fle:0, mq:0, mr:0, want:V_IDLE},
          '{r:0, br:0, ld:1, wa:5'd0, rs:5'd31, rt:5'd0,  fle:0, mq:0, mr:0, want:V_IDLE},
          '{r:0, br:0, ld:1, wa:5'd7, rs:5'd7,  rt:5'd30, fle:0, mq:0, mr:0, want:V_HAZ},
          '{r:0, br:0, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:1, mq:0, mr:0, want:V_HAZ},
          '{r:0, br:0, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:0, mr:0, want:V_IDLE}};
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      @(negedge clk);
      total++;
      if (obs() !== s[i].want) begin
        bad++; $display("FAIL load_use[%0d] got=%b want=%b", i, obs(), s[i].want);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    step_t s [6];
    s = '{'{r:0, br:1, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:0, mr:0, want:V_BRANCH},
          '{r:0, br:0, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:0, mr:0, want:V_SQUASH},
          '{r:0, br:0, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:0, mr:0, want:V_IDLE},
          '{r:0, br:1, ld:1, wa:5'd9, rs:5'd9,  rt:5'd9,  fle:1, mq:0, mr:0, want:V_BRANCH},
          '{r:0, br:0, ld:1, wa:5'd9, rs:5'd9,  rt:5'd30, fle:0, mq:0, mr:0, want:V_HAZ_SQ},
          '{r:0, br:0, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:0, mr:0, want:V_IDLE}};
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      @(negedge clk);
      total++;
      if (obs() !== s[i].want) begin
        bad++; $display("FAIL branch[%0d] got=%b want=%b", i, obs(), s[i].want);
      end
      tick();
    end
  endtask

  task automatic test_mem_wait_branch();
    step_t s [7];
    s = '{'{r:0, br:1, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:1, mr:0, want:V_MWAIT},
          '{r:0, br:1, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:1, mr:0, want:V_MWAIT},
          '{r:0, br:1, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:1, mr:0, want:V_MWAIT},
          '{r:0, br:1, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:1, mr:1, want:V_BRANCH},
          '{r:0, br:0, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:0, mr:0, want:V_SQUASH},
          '{r:0, br:0, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:0, mr:1, want:V_IDLE},
          '{r:0, br:0, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:0, mr:0, want:V_IDLE}};
    for (int i = 0; i < 7; i++) begin
      apply(s[i]);
      @(negedge clk);
      total++;
      if (obs() !== s[i].want) begin
        bad++; $display("FAIL mem_wait_branch[%0d] got=%b want=%b", i, obs(), s[i].want);
      end
      tick();
    end
  endtask

  task automatic test_redirect_wait();
    step_t s [5];
    s = '{'{r:0, br:1, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:0, mr:0, want:V_BRANCH},
          '{r:0, br:0, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:1, mr:0, want:V_MWAIT},
          '{r:0, br:0, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:1, mr:0, want:V_MWAIT},
          '{r:0, br:0, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:1, mr:1, want:V_SQUASH},
          '{r:0, br:0, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:0, mr:0, want:V_IDLE}};
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      @(negedge clk);
      total++;
      if (obs() !== s[i].want) begin
        bad++; $display("FAIL redirect_wait[%0d] got=%b want=%b", i, obs(), s[i].want);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    logic want;
    apply('{r:0, br:0, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:1, mr:0, want:V_MWAIT});
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      want = (k >= TB_TIMEOUT);
      total++;
      if (mem_timeout !== want || obs() !== V_MWAIT) begin
        bad++; $display("FAIL timeout_wait[%0d] timeout=%b want=%b out=%b", k, mem_timeout, want, obs());
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      mem_ready = (k == 0);
      mem_req   = (k == 0);
      @(negedge clk);
      total++;
      if (mem_timeout !== 1'b1 || obs() !== V_IDLE) begin
        bad++; $display("FAIL timeout_sticky[%0d] timeout=%b out=%b want 1/%b", k, mem_timeout, obs(), V_IDLE);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_wait();
    apply('{r:0, br:1, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:0, mr:0, want:V_BRANCH});
    tick();
    apply('{r:0, br:0, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:1, mr:0, want:V_MWAIT});
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (perf_stall_cycles !== exp_stalls() || perf_flush_count !== exp_flushes()) begin
      bad++; $display("FAIL perf_before_reset stalls=%0d want=%0d flushes=%0d want=%0d",
                      perf_stall_cycles, exp_stalls(), perf_flush_count, exp_flushes());
    end
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (obs() !== V_RESET) begin
        bad++; $display("FAIL reset_mid_wait[%0d] got=%b want=%b", i, obs(), V_RESET);
      end
      tick();
    end
    apply('{r:0, br:0, ld:0, wa:5'd1, rs:5'd31, rt:5'd30, fle:0, mq:1, mr:1, want:V_IDLE});
    @(negedge clk);
    total++;
    if (obs() !== V_IDLE || mem_timeout !== 1'b0 ||
        perf_stall_cycles !== 32'd0 || perf_flush_count !== 32'd0) begin
      bad++; $display("FAIL after_reset out=%b timeout=%b stalls=%0d flushes=%0d want %b/0/0/0",
                      obs(), mem_timeout, perf_stall_cycles, perf_flush_count, V_IDLE);
    end
    tick();
  endtask

  task automatic test_random();
    logic [9:0] e, o;
    for (int i = 0; i < 400; i++) begin
      rst               = ($urandom_range(0, 63) == 0);
      exec_branch_taken = ($urandom_range(0, 5) == 0);
      exec_mem_enable   = $urandom_range(0, 1);
      exec_mem_rw       = ($urandom_range(0, 3) == 0);
      exec_wb_reg       = ($urandom_range(0, 3) != 0);
      exec_write_addr   = AW'($urandom_range(0, 3));
      dec_rs_addr       = AW'($urandom_range(0, 3));
      dec_rt_addr       = AW'($urandom_range(0, 3));
      dec_rs_used       = $urandom_range(0, 1);
      dec_rt_used       = $urandom_range(0, 1);
      free_list_empty   = ($urandom_range(0, 7) == 0);
      mem_req           = $urandom_range(0, 1);
      mem_ready         = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      e = model_exp();
      o = obs();
      total++;
      if (o !== e || mem_timeout !== m_timeout) begin
        bad++; $display("FAIL random[%0d] out=%b want=%b timeout=%b want=%b", i, o, e, mem_timeout, m_timeout);
      end
      total++;
      if (perf_stall_cycles !== exp_stalls() || perf_flush_count !== exp_flushes()) begin
        bad++; $display("FAIL random_perf[%0d] stalls=%0d want=%0d flushes=%0d want=%0d",
                        i, perf_stall_cycles, exp_stalls(), perf_flush_count, exp_flushes());
      end
      total++;
      if ((o[7] & o[6]) | (o[5] & o[4]) | (o[3] & o[2]) | (o[1] & o[0])) begin
        bad++; $display("FAIL random_invariant[%0d] out=%b has stall and flush together", i, o);
      end
      tick();
    end
  endtask

  initial begin
    m_after_branch = 0; m_pending = 0; m_in_wait = 0;
    m_wait_cycles = 0; m_timeout = 0; m_stalls = 0; m_flushes = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait_branch();
    test_redirect_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the four pipeline stage registers (fetch→decode, decode→execute, execute→memory, memory→writeback) and the PC register. Detects load-use hazards, rename free-list exhaustion, taken branches resolved in execute and multi-cycle memory waits. Drives per-stage `stall`/`flush` so that stall is never needed to override flush. Sits beside the stage registers in the CPU top level and is their only stall/flush source.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5, architectural register address width
- `WAIT_CNT_WIDTH`, 8, memory-wait counter width
- `MEM_TIMEOUT`, 200, wait cycles before `mem_timeout` sets; must fit in `WAIT_CNT_WIDTH`

Ports:
- `clk`  in  1  sole clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `dec_rs_addr`, `dec_rt_addr`  in  REG_ADDR_WIDTH  decode-stage source registers
- `dec_rs_used`, `dec_rt_used`  in  1  source actually read
- `exec_mem_enable`, `exec_mem_rw`  in  1  execute-stage memory access; rw=0 is a load
- `exec_wb_reg`  in  1  execute-stage instruction writes a register
- `exec_write_addr`  in  REG_ADDR_WIDTH  its destination
- `exec_branch_taken`  in  1  execute-stage branch resolved taken
- `free_list_empty`  in  1  rename free list has no entry
- `mem_req`, `mem_ready`  in  1  memory-stage access outstanding / completing this cycle
- `pc_stall`, `pc_redirect`  out  1  hold PC / load branch target
- `stall_f2d`, `flush_f2d`, `stall_d2e`, `flush_d2e`, `stall_e2m`, `flush_e2m`, `stall_m2w`, `flush_m2w`  out  1  per-register controls
- `mem_timeout`  out  1  sticky memory-wait timeout flag
- `perf_stall_cycles`, `perf_flush_count`  out  32  performance counters

## Operation
- States: RUN, MEM_WAIT, REDIRECT. Plus `redirect_pending` bit and `wait_cnt`.
- Outputs are combinational from state plus inputs. Unlisted outputs are 0.
- Condition priority, evaluated every cycle:
  1. Memory wait: `mem_req & !mem_ready`.
     - Assert `pc_stall`, `stall_f2d`, `stall_d2e`, `stall_e2m`, `flush_m2w`.
     - Next state MEM_WAIT.
     - A concurrent `exec_branch_taken` is not acted on. The branch stays held in execute.
  2. Branch taken.
     - Assert `pc_redirect`, `flush_f2d`, `flush_d2e`. No stalls.
     - Next state REDIRECT.
     - Load-use and free-list conditions are ignored this cycle.
  3. Load-use: `exec_mem_enable & !exec_mem_rw & exec_wb_reg & exec_write_addr!=0` matches a used decode source.
     - Assert `pc_stall`, `stall_f2d`, `flush_d2e`.
  4. Free list empty: same outputs as load-use.
- REDIRECT (entered for exactly one cycle):
  - Assert `flush_f2d` to squash the wrong-path fetch already in flight.
  - Combine with any load-use/free-list outputs, except that `stall_f2d` is suppressed.
  - Next state RUN.
  - If a memory wait occurs in REDIRECT: apply condition 1, set `redirect_pending`, go to MEM_WAIT.
- MEM_WAIT:
  - `wait_cnt` increments each cycle, saturating.
  - When `wait_cnt == MEM_TIMEOUT`, set `mem_timeout`. It is cleared only by `rst`.
  - On `mem_ready`: release the stalls. If `redirect_pending`, assert `flush_f2d` and clear the bit. Then apply conditions 2–4.
  - Leaving MEM_WAIT clears `wait_cnt`.
- Invariant: a register is never given stall=1 and flush=1 in the same cycle.

## Timing
- Zero-cycle latency: outputs respond to inputs in the same cycle. State updates at the next rising edge.
- Load-use costs exactly one bubble. The next cycle the load is in memory and the hazard clears.
- Taken branch costs two squashed slots: the decode slot plus the REDIRECT-cycle fetch.
- Reset (`rst`=1 at an edge):
  - state←RUN, `redirect_pending`←0, `wait_cnt`←0, `mem_timeout`←0, counters←0.
  - While `rst` is high, all four flush outputs are 1, all stall outputs are 0, and `pc_redirect`=0.
  - Reset mid-MEM_WAIT abandons the wait with no pending flush.
- `mem_ready` without `mem_req` is ignored.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `perf_stall_cycles` increments on every cycle with `pc_stall`=1.
  - `perf_flush_count` increments on every cycle with `pc_redirect`=1.
  - Both are 32-bit, saturate at all-ones and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built. All other behaviour is identical.

## Test plan
- Load into r5 in execute, decode reads rt=r5 → one cycle of `pc_stall`=`stall_f2d`=`flush_d2e`=1, then all 0. Same case with destination r0 → no stall.
- `exec_branch_taken`=1 in RUN → cycle 0: `pc_redirect`=`flush_f2d`=`flush_d2e`=1; cycle 1 (REDIRECT): `flush_f2d`=1 only; cycle 2: RUN, all 0.
- `mem_req`=1, `mem_ready` low for 3 cycles with branch taken → 3 cycles of stall on PC/f2d/d2e/e2m and `flush_m2w`; branch flush occurs on the `mem_ready` cycle.
- Memory wait starting in REDIRECT, ready after 2 cycles → `flush_f2d`=1 on the ready cycle (pending redirect honoured).
- `mem_ready` held low with `MEM_TIMEOUT`=4 → `mem_timeout` rises after 4 wait cycles and stays high after `mem_ready` until `rst`.
- `rst` asserted mid-MEM_WAIT → all flushes 1, stalls 0; after release: RUN, `mem_timeout`=0, counters 0 (with `HAZARD_PERF_CNT_EN`, `perf_stall_cycles` counts exactly the stalled cycles before reset).
